// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - state type, sizes and round-robin pick function for mux8_rr_arbiter
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '0;
    // Scan from the far end so the candidate nearest ptr is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_8NtoN.sv
// rtl/mux_8NtoN.sv - parametrizable 8:1 N-bit mux with enable, output forced to 0 when disabled
module mux_8NtoN #(
  parameter int N = 32
) (
  input  logic           rst,
  input  logic           en,
  input  logic [2:0]     sel,
  input  logic [8*N-1:0] din,
  output logic [N-1:0]   dout
);

  always_comb begin
    dout = '0;
    if (rst && en) begin
      dout = din[sel*N +: N];
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - 8-way round-robin burst arbiter over a shared N-bit mux
// Optional forced release on stall timeout when ARB_TIMEOUT_EN is defined.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   last_i,
  input  logic [NUM_REQ*N-1:0] data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [N-1:0]         data_o,
  output logic [NUM_REQ-1:0]   ready_o,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   scan_ptr;
  logic               xfer;
  logic               rel;
  logic               force_rel;
  pick_t              pick;

  assign busy_o  = (state_q == GRANT);
  assign gnt_o   = gnt_q;
  assign sel_o   = sel_q;
  assign valid_o = busy_o & req_i[sel_q];
  assign ready_o = gnt_q & {NUM_REQ{ready_i}};
  assign xfer    = valid_o & ready_i;
  assign rel     = (xfer & last_i[sel_q]) | force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] stall_q, stall_d;

  // Fires on the TIMEOUT-th consecutive stalled grant cycle.
  assign force_rel = busy_o & ~xfer & (stall_q == CNT_W'(TIMEOUT - 1));
  assign timeout_o = force_rel;

  always_comb begin
    stall_d = stall_q + CNT_W'(1);
    if (!busy_o || rel || xfer) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0 & (TIMEOUT > 0);
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    scan_ptr = ptr_q;
    if (busy_o && rel) begin
      scan_ptr = sel_q + SEL_W'(1);
    end
    pick = rr_pick(req_i, scan_ptr);
    // Arbitrate from IDLE, or re-arbitrate in the release cycle for a zero-bubble handover.
    if (!busy_o || rel) begin
      ptr_d = scan_ptr;
      if (pick.found) begin
        state_d = GRANT;
        gnt_d   = NUM_REQ'(1) << pick.idx;
        sel_d   = pick.idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  mux_8NtoN #(
    .N (N)
  ) u_mux (
    .rst  (1'b1),
    .en   (busy_o),
    .sel  (sel_q),
    .din  (data_i),
    .dout (data_o)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed table-driven bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     req_i;
  logic [7:0]     last_i;
  logic [8*N-1:0] data_i;
  logic           ready_i;
  logic           valid_o;
  logic [N-1:0]   data_o;
  logic [7:0]     ready_o;
  logic [7:0]     gnt_o;
  logic [2:0]     sel_o;
  logic           busy_o;
  logic           timeout_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [7:0] gnt;
    logic       valid;
    logic [7:0] rdy_o;
  } vec_t;

  vec_t vecs[31];

  always #5 clk = ~clk;

  mux8_rr_arbiter #(
    .N       (N),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .last_i    (last_i),
    .data_i    (data_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ready_o   (ready_o),
    .gnt_o     (gnt_o),
    .sel_o     (sel_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  function automatic logic [N-1:0] lane(input int k);
    return 32'hA500_0000 | 32'(k * 257);
  endfunction

  function automatic int onehot_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] req, input logic [7:0] last, input logic rdy,
                              input logic [7:0] gnt, input logic valid, input logic [7:0] rdy_o);
    vec_t v;
    v.req = req; v.last = last; v.rdy = rdy;
    v.gnt = gnt; v.valid = valid; v.rdy_o = rdy_o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [7:0] gnt, input logic valid,
                         input logic [7:0] rdy_o);
    chk({tag, " gnt"},   32'(gnt_o), 32'(gnt));
    chk({tag, " valid"}, 32'(valid_o), 32'(valid));
    chk({tag, " ready"}, 32'(ready_o), 32'(rdy_o));
    chk({tag, " busy"},  32'(busy_o), 32'(gnt != 8'h00));
    chk({tag, " data"},  data_o, (gnt == 8'h00) ? 32'h0 : lane(onehot_idx(gnt)));
    if (gnt != 8'h00) chk({tag, " sel"}, 32'(sel_o), 32'(onehot_idx(gnt)));
    chk({tag, " timeout"}, 32'(timeout_o), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) data_i[k*N +: N] = lane(k);

    // Rotation with single-beat bursts from every requester.
    vecs[0] = mk(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      vecs[i] = mk(8'hFF, 8'hFF, 1'b1, 8'(1 << (i - 1)), 1'b1, 8'(1 << (i - 1)));
    end
    vecs[9]  = mk(8'h25, 8'h01, 1'b1, 8'h01, 1'b1, 8'h01);
    // Three-beat burst from requester 2 while 5 waits.
    vecs[10] = mk(8'h24, 8'h00, 1'b1, 8'h04, 1'b1, 8'h04);
    vecs[11] = mk(8'h24, 8'h00, 1'b1, 8'h04, 1'b1, 8'h04);
    vecs[12] = mk(8'h24, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04);
    // Requester 5 burst with four backpressure cycles.
    vecs[13] = mk(8'h24, 8'h00, 1'b1, 8'h20, 1'b1, 8'h20);
    for (int i = 14; i <= 17; i++) vecs[i] = mk(8'h24, 8'h00, 1'b0, 8'h20, 1'b1, 8'h00);
    vecs[18] = mk(8'h24, 8'h20, 1'b1, 8'h20, 1'b1, 8'h20);
    vecs[19] = mk(8'h4C, 8'h04, 1'b1, 8'h04, 1'b1, 8'h04);
    // Requester 3 drops req mid-burst; lock kept against requester 6.
    for (int i = 20; i <= 24; i++) vecs[i] = mk(8'h40, 8'h00, 1'b1, 8'h08, 1'b0, 8'h08);
    vecs[25] = mk(8'h48, 8'h08, 1'b1, 8'h08, 1'b1, 8'h08);
    vecs[26] = mk(8'h40, 8'h00, 1'b0, 8'h40, 1'b1, 8'h00);
    vecs[27] = mk(8'h00, 8'h00, 1'b1, 8'h40, 1'b0, 8'h40);
    vecs[28] = mk(8'h40, 8'h40, 1'b1, 8'h40, 1'b1, 8'h40);
    vecs[29] = mk(8'h41, 8'h40, 1'b1, 8'h40, 1'b1, 8'h40);
    vecs[30] = mk(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01);

    rst = 1'b0; req_i = 8'hFF; last_i = 8'hFF; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_row("reset", 8'h00, 1'b0, 8'h00);
    chk("reset sel", 32'(sel_o), 32'h0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 31; i++) begin
      req_i = vecs[i].req; last_i = vecs[i].last; ready_i = vecs[i].rdy;
      #1;
      chk_row($sformatf("row%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].rdy_o);
      @(negedge clk);
    end

    // Asynchronous reset between edges mid-burst.
    req_i = 8'h01; last_i = 8'h00; ready_i = 1'b1;
    #1;
    chk("pre-rst valid", 32'(valid_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async gnt", 32'(gnt_o), 32'h0);
    chk("async valid", 32'(valid_o), 32'h0);
    chk("async data", data_o, 32'h0);
    chk("async busy", 32'(busy_o), 32'h0);
    @(negedge clk);
    req_i = 8'h80; rst = 1'b1;
    #1;
    chk("post-rst idle gnt", 32'(gnt_o), 32'h0);
    @(negedge clk);
    #1;
    chk("post-rst gnt", 32'(gnt_o), 32'h80);
    chk("post-rst sel", 32'(sel_o), 32'h7);
    chk("post-rst data", data_o, lane(7));

    // Stall requester 7 with requester 1 waiting.
    req_i = 8'h82; ready_i = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("stall%0d timeout", k), 32'(timeout_o), 32'(k == 16));
      chk($sformatf("stall%0d gnt", k), 32'(gnt_o), 32'h80);
      @(negedge clk);
      #1;
    end
    chk("after timeout gnt", 32'(gnt_o), 32'h02);
    chk("after timeout pulse", 32'(timeout_o), 32'h0);
`else
    for (int k = 1; k <= 100; k++) begin
      chk($sformatf("hold%0d gnt", k), 32'(gnt_o), 32'h80);
      chk($sformatf("hold%0d timeout", k), 32'(timeout_o), 32'h0);
      @(negedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
